// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM encoding, ALU select width and effective-length helper for alu_mp_sequencer.
package alu_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ALU_SEL_W = 3;

    // A zero or oversized length means "use every word".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned words);
        return (len == 0 || len > words) ? words : len;
    endfunction

endpackage

// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: drives a BITS-wide combinational ALU word by word to run one WORDS-wide operation.
// Optional ALU_MP_SEQUENCER_FLUSH_EN adds a flush input that aborts RUN/DONE back to IDLE.
module alu_mp_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int WORDS = 4,
    parameter int LEN_W = $clog2(WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ALU_MP_SEQUENCER_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ALU_SEL_W-1:0]  req_sel,
    input  logic                  req_cin,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [BITS*WORDS-1:0] req_a,
    input  logic [BITS*WORDS-1:0] req_b,
    output logic [ALU_SEL_W-1:0]  alu_sel,
    output logic                  alu_cin,
    output logic [BITS-1:0]       alu_a,
    output logic [BITS-1:0]       alu_b,
    input  logic [BITS-1:0]       alu_out,
    input  logic                  alu_cout,
    input  logic                  alu_statv,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS*WORDS-1:0] rsp_out,
    output logic                  rsp_cout,
    output logic                  rsp_v,
    output logic                  rsp_z
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [1:0]                       state_q, state_d;
    logic [LEN_W-1:0]                 cnt_q, cnt_d, len_q, len_d;
    logic [ALU_SEL_W-1:0]             sel_q, sel_d;
    logic                             cin_q, cin_d, cout_q, cout_d, v_q, v_d, z_q, z_d;
    logic [WORDS-1:0][BITS-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic [IDX_W-1:0]                 idx;
    logic                             run, last, flush_w;

`ifdef ALU_MP_SEQUENCER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign run  = state_q == ST_RUN;
    assign idx  = cnt_q[IDX_W-1:0];
    assign last = (cnt_q + LEN_W'(1)) == len_q;

    // ALU operands come only from latched registers, never straight from the request.
    assign alu_sel   = run ? sel_q : '0;
    assign alu_a     = run ? a_q[idx] : '0;
    assign alu_b     = run ? b_q[idx] : '0;
    assign alu_cin   = run & ((cnt_q == '0) ? cin_q : cout_q);

    assign req_ready = state_q == ST_IDLE;
    assign rsp_valid = state_q == ST_DONE;
    assign rsp_out   = res_q;
    assign rsp_cout  = cout_q;
    assign rsp_v     = v_q;
    assign rsp_z     = z_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        v_d     = v_q;
        z_d     = z_q;
        if (state_q == ST_IDLE) begin
            if (req_valid) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                len_d   = LEN_W'(eff_len(32'(req_len), WORDS));
                sel_d   = req_sel;
                cin_d   = req_cin;
                a_d     = req_a;
                b_d     = req_b;
                res_d   = '0;
                cout_d  = 1'b0;
                v_d     = 1'b0;
                z_d     = 1'b1;
            end
        end else if (flush_w) begin
            state_d = ST_IDLE;
            res_d   = '0;
        end else if (run) begin
            res_d[idx] = alu_out;
            cout_d     = alu_cout;
            v_d        = alu_statv;
            z_d        = z_q & (alu_out == '0);
            cnt_d      = cnt_q + LEN_W'(1);
            state_d    = last ? ST_DONE : ST_RUN;
        end else if (rsp_ready || state_q != ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sel_q   <= '0;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
            cin_q   <= cin_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

endmodule
